// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation is in flight at a time: IDLE grants, EXEC samples the ALU, RESP holds the result.
module alu_arbiter #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         ReqValid0,
  input  logic         ReqValid1,
  input  logic [W-1:0] ReqA0,
  input  logic [W-1:0] ReqB0,
  input  logic [W-1:0] ReqA1,
  input  logic [W-1:0] ReqB1,
  input  logic [3:0]   ReqOp0,
  input  logic [3:0]   ReqOp1,
  output logic         ReqReady0,
  output logic         ReqReady1,
  output logic [W-1:0] AluA,
  output logic [W-1:0] AluB,
  output logic [3:0]   AluOp,
  input  logic [W-1:0] AluOut,
  output logic         RspValid,
  output logic         RspId,
  output logic [W-1:0] RspOut,
  output logic         RspZero,
  output logic         RspParity,
  output logic         RspErr,
  input  logic         RspReady
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR0 = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_BNE = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  state_t         state_nxt;
  logic           grant;
  logic           grant_id;
  logic           last_id;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;
  logic [3:0]     op_sel;

  logic [W-1:0]   a_p0;
  logic [W-1:0]   b_p0;
  logic [3:0]     op_p0;
  logic           id_p0;

  logic [W-1:0]   out_p1;
  logic           zero_p1;
  logic           parity_p1;
  logic           err_p1;

  function automatic logic op_supported(input logic [3:0] op);
    case (op)
      OP_ADD, OP_AND, OP_OR0, OP_XOR, OP_BNE, OP_SLL, OP_SRL: op_supported = 1'b1;
      default:                                              op_supported = 1'b0;
    endcase
  endfunction

  // Unsupported opcodes force a clean zero result so AluOut garbage never leaks out.
  function automatic logic [W-1:0] clean_result(input logic [W-1:0] res, input logic ok);
    clean_result = ok ? res : '0;
  endfunction

  function automatic logic parity_of(input logic [W-1:0] val);
    parity_of = ^val;
  endfunction

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_id  = 1'b0;
    case (state)
      IDLE: begin
        // Reset_n gates the grant so nothing is accepted while reset is held.
        if (Reset_n && (ReqValid0 || ReqValid1)) begin
          grant     = 1'b1;
          grant_id  = (ReqValid0 && ReqValid1) ? ~last_id : ReqValid1;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (RspReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_sel  = grant_id ? ReqA1  : ReqA0;
    b_sel  = grant_id ? ReqB1  : ReqB0;
    op_sel = grant_id ? ReqOp1 : ReqOp0;
  end

  assign ReqReady0 = grant & ~grant_id;
  assign ReqReady1 = grant &  grant_id;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      last_id <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == RESP && RspReady) last_id <= id_p0;
    end
  end

  // Stage p0: operand capture at grant.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a_p0  <= '0;
      b_p0  <= '0;
      op_p0 <= '0;
      id_p0 <= 1'b0;
    end else if (grant) begin
      a_p0  <= a_sel;
      b_p0  <= b_sel;
      op_p0 <= op_sel;
      id_p0 <= grant_id;
    end
  end

  // Stage p1: ALU result capture at end of EXEC.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_p1    <= '0;
      zero_p1   <= 1'b1;
      parity_p1 <= 1'b0;
      err_p1    <= 1'b0;
    end else if (state == EXEC) begin
      out_p1    <= clean_result(AluOut, op_supported(op_p0));
      zero_p1   <= (clean_result(AluOut, op_supported(op_p0)) == '0);
      parity_p1 <= parity_of(clean_result(AluOut, op_supported(op_p0)));
      err_p1    <= ~op_supported(op_p0);
    end
  end

  assign AluA      = a_p0;
  assign AluB      = b_p0;
  assign AluOp     = op_p0;
  assign RspValid  = (state == RESP);
  assign RspId     = id_p0;
  assign RspOut    = out_p1;
  assign RspZero   = zero_p1;
  assign RspParity = parity_p1;
  assign RspErr    = err_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the shared ALU.
module tb_alu_arbiter;

  localparam int W = 8;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR0 = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_BNE = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         ReqValid0, ReqValid1;
  logic [W-1:0] ReqA0, ReqB0, ReqA1, ReqB1;
  logic [3:0]   ReqOp0, ReqOp1;
  logic         ReqReady0, ReqReady1;
  logic [W-1:0] AluA, AluB;
  logic [3:0]   AluOp;
  logic [W-1:0] AluOut;
  logic         RspValid, RspId, RspZero, RspParity, RspErr;
  logic [W-1:0] RspOut;
  logic         RspReady;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.W(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .ReqValid0(ReqValid0), .ReqValid1(ReqValid1),
    .ReqA0(ReqA0), .ReqB0(ReqB0), .ReqA1(ReqA1), .ReqB1(ReqB1),
    .ReqOp0(ReqOp0), .ReqOp1(ReqOp1),
    .ReqReady0(ReqReady0), .ReqReady1(ReqReady1),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluOut(AluOut),
    .RspValid(RspValid), .RspId(RspId), .RspOut(RspOut),
    .RspZero(RspZero), .RspParity(RspParity), .RspErr(RspErr),
    .RspReady(RspReady)
  );

  always #5 Clk = ~Clk;

  // Shared combinational ALU; unknown opcodes return a nonzero pattern on purpose.
  always_comb begin
    case (AluOp)
      OP_ADD:  AluOut = AluA + AluB;
      OP_SUB:  AluOut = AluA - AluB;
      OP_AND:  AluOut = AluA & AluB;
      OP_OR0:  AluOut = AluA | AluB;
      OP_XOR:  AluOut = AluA ^ AluB;
      OP_BNE:  AluOut = (AluA != AluB) ? 8'd1 : 8'd0;
      OP_SLL:  AluOut = AluA << AluB[2:0];
      OP_SRL:  AluOut = AluA >> AluB[2:0];
      default: AluOut = AluA ^ AluB;
    endcase
  end

  task automatic test_reset();
    Reset_n = 1'b0;
    ReqValid0 = 1'b1; ReqValid1 = 1'b1;
    ReqA0 = 8'd0; ReqB0 = 8'd0; ReqA1 = 8'd0; ReqB1 = 8'd0;
    ReqOp0 = OP_ADD; ReqOp1 = OP_ADD; RspReady = 1'b0;
    repeat (2) @(posedge Clk);
    #2;
    total++;
    if ({ReqReady0, ReqReady1} !== 2'b00) begin
      bad++; $display("FAIL reset_ready: got %b want 00", {ReqReady0, ReqReady1});
    end
    total++;
    if ({RspValid, RspId, RspErr, RspParity, RspZero} !== 5'b00001) begin
      bad++; $display("FAIL reset_rsp_flags: got %b want 00001", {RspValid, RspId, RspErr, RspParity, RspZero});
    end
    total++;
    if ({RspOut, AluA, AluB, AluOp} !== 28'h0) begin
      bad++; $display("FAIL reset_data: got out=%h a=%h b=%h op=%h want 0", RspOut, AluA, AluB, AluOp);
    end
    ReqValid0 = 1'b0; ReqValid1 = 1'b0;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_single();
    ReqValid0 = 1'b1; ReqA0 = 8'd1; ReqB0 = 8'd1; ReqOp0 = OP_ADD; RspReady = 1'b1;
    #1;
    total++;
    if ({ReqReady0, ReqReady1} !== 2'b10) begin
      bad++; $display("FAIL single_grant: got %b want 10", {ReqReady0, ReqReady1});
    end
    @(posedge Clk); #1;
    ReqValid0 = 1'b0;
    #1;
    total++;
    if ({RspValid, ReqReady0, AluA, AluB, AluOp} !== {1'b0, 1'b0, 8'd1, 8'd1, OP_ADD}) begin
      bad++; $display("FAIL single_exec: got v=%b rdy=%b a=%h b=%h op=%h want v=0 rdy=0 a=01 b=01 op=0", RspValid, ReqReady0, AluA, AluB, AluOp);
    end
    @(posedge Clk); #2;
    total++;
    if ({RspValid, RspOut, RspZero, RspParity, RspId, RspErr} !== {1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL single_rsp: got v=%b out=%h z=%b p=%b id=%b e=%b want v=1 out=02 z=0 p=1 id=0 e=0", RspValid, RspOut, RspZero, RspParity, RspId, RspErr);
    end
    @(posedge Clk); #2;
    total++;
    if (RspValid !== 1'b0) begin
      bad++; $display("FAIL single_idle: got RspValid=%b want 0", RspValid);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_tie();
    logic [2:0] exp_order;
    int cnt;
    exp_order = 3'b010;
    Reset_n = 1'b0; #2; Reset_n = 1'b1;
    @(posedge Clk); #1;
    ReqValid0 = 1'b1; ReqA0 = 8'd6;  ReqB0 = 8'd6; ReqOp0 = OP_SUB;
    ReqValid1 = 1'b1; ReqA1 = 8'd15; ReqB1 = 8'd2; ReqOp1 = OP_SRL;
    RspReady = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      cnt = 0;
      while (!(ReqReady0 || ReqReady1) && cnt < 5) begin
        @(posedge Clk); #2; cnt++;
      end
      total++;
      if (cnt >= 5) begin
        bad++; $display("FAIL tie_timeout: got no grant want grant %0d", g);
      end
      total++;
      if ({ReqReady1, ReqReady0} !== {exp_order[g], ~exp_order[g]}) begin
        bad++; $display("FAIL tie_order: grant %0d got r1r0=%b want id %b", g, {ReqReady1, ReqReady0}, exp_order[g]);
      end
      @(posedge Clk); #2;
      @(posedge Clk); #2;
      total++;
      if (exp_order[g] == 1'b0) begin
        if ({RspValid, RspId, RspOut, RspZero, RspParity, RspErr} !== {1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1}) begin
          bad++; $display("FAIL tie_rsp0: got v=%b id=%b out=%h z=%b p=%b e=%b want v=1 id=0 out=00 z=1 p=0 e=1", RspValid, RspId, RspOut, RspZero, RspParity, RspErr);
        end
      end else begin
        if ({RspValid, RspId, RspOut, RspZero, RspParity, RspErr} !== {1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0}) begin
          bad++; $display("FAIL tie_rsp1: got v=%b id=%b out=%h z=%b p=%b e=%b want v=1 id=1 out=03 z=0 p=0 e=0", RspValid, RspId, RspOut, RspZero, RspParity, RspErr);
        end
      end
      total++;
      if ({ReqReady0, ReqReady1} !== 2'b00) begin
        bad++; $display("FAIL tie_handshake_nogrant: got %b want 00", {ReqReady0, ReqReady1});
      end
      @(posedge Clk); #2;
    end
    ReqValid0 = 1'b0; ReqValid1 = 1'b0;
    @(posedge Clk); @(posedge Clk); @(posedge Clk); #1;
  endtask

  task automatic test_backpressure();
    RspReady = 1'b0;
    ReqValid1 = 1'b1; ReqA1 = 8'd5; ReqB1 = 8'd3; ReqOp1 = OP_ADD;
    #1;
    total++;
    if ({ReqReady0, ReqReady1} !== 2'b01) begin
      bad++; $display("FAIL bp_grant: got %b want 01", {ReqReady0, ReqReady1});
    end
    @(posedge Clk); #1;
    ReqValid1 = 1'b0;
    ReqValid0 = 1'b1; ReqA0 = 8'hF0; ReqB0 = 8'h0F; ReqOp0 = OP_XOR;
    @(posedge Clk); #2;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({RspValid, RspId, RspOut, RspZero, RspParity, RspErr, ReqReady0, ReqReady1} !==
          {1'b1, 1'b1, 8'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        bad++; $display("FAIL bp_hold: cycle %0d got v=%b id=%b out=%h z=%b p=%b e=%b rdy=%b%b want v=1 id=1 out=08 z=0 p=1 e=0 rdy=00",
                        i, RspValid, RspId, RspOut, RspZero, RspParity, RspErr, ReqReady0, ReqReady1);
      end
      @(posedge Clk); #2;
    end
    RspReady = 1'b1;
    #1;
    total++;
    if ({RspValid, ReqReady0} !== 2'b10) begin
      bad++; $display("FAIL bp_release_cycle: got v=%b rdy0=%b want v=1 rdy0=0", RspValid, ReqReady0);
    end
    @(posedge Clk); #2;
    total++;
    if ({RspValid, ReqReady0} !== 2'b01) begin
      bad++; $display("FAIL bp_next_grant: got v=%b rdy0=%b want v=0 rdy0=1", RspValid, ReqReady0);
    end
    @(posedge Clk); #1;
    ReqValid0 = 1'b0;
    @(posedge Clk); #2;
    total++;
    if ({RspValid, RspId, RspOut, RspParity, RspZero} !== {1'b1, 1'b0, 8'hFF, 1'b0, 1'b0}) begin
      bad++; $display("FAIL bp_second_rsp: got v=%b id=%b out=%h p=%b z=%b want v=1 id=0 out=ff p=0 z=0", RspValid, RspId, RspOut, RspParity, RspZero);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_wrap_err();
    RspReady = 1'b1;
    ReqValid0 = 1'b1; ReqA0 = 8'd255; ReqB0 = 8'd1; ReqOp0 = OP_ADD;
    @(posedge Clk); #1;
    ReqValid0 = 1'b0;
    @(posedge Clk); #2;
    total++;
    if ({RspValid, RspOut, RspZero, RspErr, RspParity} !== {1'b1, 8'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL wrap_add: got v=%b out=%h z=%b e=%b p=%b want v=1 out=00 z=1 e=0 p=0", RspValid, RspOut, RspZero, RspErr, RspParity);
    end
    @(posedge Clk); #1;
    ReqValid0 = 1'b1; ReqA0 = 8'd3; ReqB0 = 8'd5; ReqOp0 = 4'hF;
    @(posedge Clk); #1;
    ReqValid0 = 1'b0;
    @(posedge Clk); #2;
    total++;
    if ({RspValid, RspOut, RspZero, RspErr, RspParity} !== {1'b1, 8'd0, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL err_op: got v=%b out=%h z=%b e=%b p=%b want v=1 out=00 z=1 e=1 p=0", RspValid, RspOut, RspZero, RspErr, RspParity);
    end
    @(posedge Clk); #1;
    ReqValid0 = 1'b1; ReqA0 = 8'h81; ReqB0 = 8'd1; ReqOp0 = OP_SLL;
    @(posedge Clk); #1;
    ReqValid0 = 1'b0;
    @(posedge Clk); #2;
    total++;
    if ({RspOut, RspErr, RspParity} !== {8'h02, 1'b0, 1'b1}) begin
      bad++; $display("FAIL sll_wrap: got out=%h e=%b p=%b want out=02 e=0 p=1", RspOut, RspErr, RspParity);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid();
    RspReady = 1'b1;
    ReqValid1 = 1'b1; ReqA1 = 8'd1; ReqB1 = 8'd2; ReqOp1 = OP_OR0;
    @(posedge Clk); #1;
    ReqValid1 = 1'b1; ReqValid0 = 1'b1;
    ReqA0 = 8'd9; ReqB0 = 8'd9; ReqOp0 = OP_AND;
    #1;
    Reset_n = 1'b0;
    #1;
    total++;
    if ({RspValid, ReqReady0, ReqReady1, RspId, RspErr, RspParity, RspZero} !== 7'b0000001) begin
      bad++; $display("FAIL midrst_flags: got v=%b r0=%b r1=%b id=%b e=%b p=%b z=%b want 0000001",
                      RspValid, ReqReady0, ReqReady1, RspId, RspErr, RspParity, RspZero);
    end
    total++;
    if ({RspOut, AluA, AluB, AluOp} !== 28'h0) begin
      bad++; $display("FAIL midrst_data: got out=%h a=%h b=%h op=%h want 0", RspOut, AluA, AluB, AluOp);
    end
    @(posedge Clk); #2;
    total++;
    if (RspValid !== 1'b0) begin
      bad++; $display("FAIL midrst_no_rsp: got RspValid=%b want 0", RspValid);
    end
    Reset_n = 1'b1;
    #1;
    total++;
    if ({ReqReady0, ReqReady1} !== 2'b10) begin
      bad++; $display("FAIL midrst_tie: got r0r1=%b want 10", {ReqReady0, ReqReady1});
    end
    @(posedge Clk); #1;
    ReqValid0 = 1'b0; ReqValid1 = 1'b0;
    @(posedge Clk); #2;
    total++;
    if ({RspValid, RspId, RspOut, RspZero} !== {1'b1, 1'b0, 8'd9, 1'b0}) begin
      bad++; $display("FAIL midrst_first_rsp: got v=%b id=%b out=%h z=%b want v=1 id=0 out=09 z=0", RspValid, RspId, RspOut, RspZero);
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_wrap_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
